node_mission_sequencer: RTL and testbench

//  Mission-level controller above the line follower. It counts field nodes (crossings where
//  l, c and r are all dark) and arbitrates the two motor channels. Between nodes it passes
//  the line follower's commands straight through. At each node it takes over the motors to

---
 rtl/node_mission_sequencer.sv | 234 +++++++++++++++++++++++
 tb/tb_node_mission_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/node_mission_sequencer.sv
// Mission sequencer: counts field nodes and arbitrates the motors between line follower and node actions.
// Optional macro PROBE_TIMEOUT_EN bounds the soil-probe wait and faults on expiry.
module node_mission_sequencer #(
    parameter logic [11:0] THRESH    = 12'd3000,
    parameter int          NODE_DEB  = 4,
    parameter int          ALIGN_CYC = 200,
    parameter int          TURN_MIN  = 100,
    parameter int          TURN_TMO  = 5000,
    parameter int          PROBE_TMO = 20000,
    parameter int          NUM_NODES = 6,
    parameter logic [15:0] MISSION   = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [11:0] l,
    input  logic [11:0] c,
    input  logic [11:0] r,
    input  logic [1:0]  lf_m1,
    input  logic [1:0]  lf_m2,
    input  logic        probe_done,
    output logic [1:0]  m1,
    output logic [1:0]  m2,
    output logic        probe_req,
    output logic [2:0]  node_idx,
    output logic        done,
    output logic        fault,
    output logic [2:0]  state
);

    localparam int CNT_MAX_AT = (ALIGN_CYC > TURN_TMO) ? ALIGN_CYC : TURN_TMO;
    localparam int CNT_MAX    = (CNT_MAX_AT > PROBE_TMO) ? CNT_MAX_AT : PROBE_TMO;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);
    localparam int DEB_W      = $clog2(NODE_DEB + 1);

    localparam logic [CNT_W-1:0] ALIGN_LAST = CNT_W'(ALIGN_CYC - 1);
    localparam logic [CNT_W-1:0] TURN_LAST  = CNT_W'(TURN_TMO - 1);
    localparam logic [CNT_W-1:0] TURN_MINC  = CNT_W'(TURN_MIN);
`ifdef PROBE_TIMEOUT_EN
    localparam logic [CNT_W-1:0] PROBE_LAST = CNT_W'(PROBE_TMO - 1);
`endif
    localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(NODE_DEB - 1);
    localparam logic [DEB_W-1:0] DEB_MAX    = DEB_W'(NODE_DEB);
    localparam logic [2:0]       LAST_NODE  = 3'(NUM_NODES - 1);

    localparam logic [1:0] MOT_STOP = 2'b00;
    localparam logic [1:0] MOT_REV  = 2'b01;
    localparam logic [1:0] MOT_FWD  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FOLLOW = 3'd1,
        S_ALIGN  = 3'd2,
        S_TURN   = 3'd3,
        S_SAMPLE = 3'd4,
        S_DONE   = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    state_t           cur;
    logic [CNT_W-1:0] cnt;
    logic [DEB_W-1:0] deb_cnt;
    logic             armed;
    logic             dark;
    logic             reacq;
    logic             last_node;
    logic [1:0]       node_op;

    assign dark      = (l > THRESH) && (c > THRESH) && (r > THRESH);
    assign reacq     = (cnt >= TURN_MINC) && (c > THRESH);
    assign last_node = (node_idx == LAST_NODE);
    assign node_op   = MISSION[{node_idx, 1'b0} +: 2];
    assign state     = cur;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur       <= S_IDLE;
            cnt       <= '0;
            deb_cnt   <= '0;
            armed     <= 1'b0;
            m1        <= MOT_STOP;
            m2        <= MOT_STOP;
            probe_req <= 1'b0;
            node_idx  <= 3'd0;
            done      <= 1'b0;
            fault     <= 1'b0;
        end else begin
            case (cur)
                S_IDLE: begin
                    m1 <= MOT_STOP;
                    m2 <= MOT_STOP;
                    if (start) begin
                        cur      <= S_FOLLOW;
                        node_idx <= 3'd0;
                        armed    <= 1'b1;
                        deb_cnt  <= '0;
                        m1       <= lf_m1;
                        m2       <= lf_m2;
                    end
                end
                // Pass-through; re-arming needs one non-dark cycle so a held node is counted once.
                S_FOLLOW: begin
                    m1 <= lf_m1;
                    m2 <= lf_m2;
                    if (dark) begin
                        if (deb_cnt != DEB_MAX) deb_cnt <= deb_cnt + 1'b1;
                        if (armed && deb_cnt == DEB_LAST) begin
                            cur     <= S_ALIGN;
                            armed   <= 1'b0;
                            deb_cnt <= '0;
                            cnt     <= '0;
                            m1      <= MOT_FWD;
                            m2      <= MOT_FWD;
                        end
                    end else begin
                        deb_cnt <= '0;
                        armed   <= 1'b1;
                    end
                end
                S_ALIGN: begin
                    if (cnt == ALIGN_LAST) begin
                        cnt <= '0;
                        case (node_op)
                            2'b00: begin
                                if (last_node) begin
                                    cur  <= S_DONE;
                                    done <= 1'b1;
                                    m1   <= MOT_STOP;
                                    m2   <= MOT_STOP;
                                end else begin
                                    cur      <= S_FOLLOW;
                                    node_idx <= node_idx + 3'd1;
                                    m1       <= lf_m1;
                                    m2       <= lf_m2;
                                end
                            end
                            2'b01: begin
                                cur <= S_TURN;
                                m1  <= MOT_REV;
                                m2  <= MOT_FWD;
                            end
                            2'b10: begin
                                cur <= S_TURN;
                                m1  <= MOT_FWD;
                                m2  <= MOT_REV;
                            end
                            default: begin
                                cur       <= S_SAMPLE;
                                m1        <= MOT_STOP;
                                m2        <= MOT_STOP;
                                probe_req <= 1'b1;
                            end
                        endcase
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                // Reacquisition is tested before the timeout so it wins a tie.
                S_TURN: begin
                    if (reacq) begin
                        if (last_node) begin
                            cur  <= S_DONE;
                            done <= 1'b1;
                            m1   <= MOT_STOP;
                            m2   <= MOT_STOP;
                        end else begin
                            cur      <= S_FOLLOW;
                            node_idx <= node_idx + 3'd1;
                            m1       <= lf_m1;
                            m2       <= lf_m2;
                        end
                    end else if (cnt == TURN_LAST) begin
                        cur   <= S_FAULT;
                        fault <= 1'b1;
                        m1    <= MOT_STOP;
                        m2    <= MOT_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_SAMPLE: begin
                    m1 <= MOT_STOP;
                    m2 <= MOT_STOP;
                    if (probe_req && probe_done) begin
                        probe_req <= 1'b0;
                        if (last_node) begin
                            cur  <= S_DONE;
                            done <= 1'b1;
                        end else begin
                            cur      <= S_FOLLOW;
                            node_idx <= node_idx + 3'd1;
                            m1       <= lf_m1;
                            m2       <= lf_m2;
                        end
                    end
`ifdef PROBE_TIMEOUT_EN
                    else if (cnt == PROBE_LAST) begin
                        cur       <= S_FAULT;
                        fault     <= 1'b1;
                        probe_req <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                S_DONE: begin
                    m1 <= MOT_STOP;
                    m2 <= MOT_STOP;
                    if (start) begin
                        cur      <= S_FOLLOW;
                        node_idx <= 3'd0;
                        done     <= 1'b0;
                        armed    <= 1'b0;
                        deb_cnt  <= '0;
                        m1       <= lf_m1;
                        m2       <= lf_m2;
                    end
                end
                S_FAULT: begin
                    m1        <= MOT_STOP;
                    m2        <= MOT_STOP;
                    probe_req <= 1'b0;
                    fault     <= 1'b1;
                end
                default: begin
                    cur <= S_IDLE;
                    m1  <= MOT_STOP;
                    m2  <= MOT_STOP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_node_mission_sequencer.sv
// Directed bench for node_mission_sequencer: mission of five nodes (straight, left, sample, right, straight).
module tb_node_mission_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [11:0] l, c, r;
    logic [1:0]  lf_m1, lf_m2;
    logic        probe_done;
    logic [1:0]  m1, m2;
    logic        probe_req;
    logic [2:0]  node_idx;
    logic        done;
    logic        fault;
    logic [2:0]  state;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    node_mission_sequencer #(
        .NUM_NODES (5),
        .MISSION   (16'h00B4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .l          (l),
        .c          (c),
        .r          (r),
        .lf_m1      (lf_m1),
        .lf_m2      (lf_m2),
        .probe_done (probe_done),
        .m1         (m1),
        .m2         (m2),
        .probe_req  (probe_req),
        .node_idx   (node_idx),
        .done       (done),
        .fault      (fault),
        .state      (state)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sens(input logic [11:0] lv, input logic [11:0] cv, input logic [11:0] rv);
        l = lv;
        c = cv;
        r = rv;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; probe_done = 1'b0;
        lf_m1 = 2'b10; lf_m2 = 2'b10;
        sens(12'd100, 12'd100, 12'd100);
        tick(3);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_m1", 32'(m1), 32'd0);
        chk("rst_m2", 32'(m2), 32'd0);
        chk("rst_probe", 32'(probe_req), 32'd0);
        chk("rst_idx", 32'(node_idx), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        rst_n = 1'b1;
        tick(1);

        pulse_start();
        chk("start_state", 32'(state), 32'd1);
        chk("follow_m1", 32'(m1), 32'd2);
        chk("follow_m2", 32'(m2), 32'd2);
        lf_m1 = 2'b01;
        tick(1);
        chk("follow_pass_m1", 32'(m1), 32'd1);
        lf_m1 = 2'b10;

        // Three dark cycles then a gap: too short to qualify.
        sens(12'd3500, 12'd3500, 12'd3500);
        tick(3);
        sens(12'd1000, 12'd1000, 12'd1000);
        tick(1);
        chk("deb3_state", 32'(state), 32'd1);

        // Node 0, straight.
        sens(12'd3500, 12'd3500, 12'd3500);
        tick(3);
        chk("deb_cnt3", 32'(state), 32'd1);
        tick(1);
        chk("align_state", 32'(state), 32'd2);
        lf_m1 = 2'b00; lf_m2 = 2'b00;
        tick(199);
        chk("align_end_state", 32'(state), 32'd2);
        chk("align_m1", 32'(m1), 32'd2);
        chk("align_m2", 32'(m2), 32'd2);
        tick(1);
        chk("straight_state", 32'(state), 32'd1);
        chk("straight_idx", 32'(node_idx), 32'd1);
        chk("straight_m1_lf", 32'(m1), 32'd0);
        lf_m1 = 2'b10; lf_m2 = 2'b10;
        tick(50);
        chk("armed_state", 32'(state), 32'd1);
        chk("armed_idx", 32'(node_idx), 32'd1);
        sens(12'd1000, 12'd1000, 12'd1000);
        tick(1);

        // Node 1, left turn.
        sens(12'd3500, 12'd3500, 12'd3500);
        tick(204);
        chk("left_state", 32'(state), 32'd3);
        chk("left_m1", 32'(m1), 32'd1);
        chk("left_m2", 32'(m2), 32'd2);
        sens(12'd100, 12'd100, 12'd100);
        tick(50);
        sens(12'd100, 12'd3500, 12'd100);
        tick(1);
        chk("turn_early_c", 32'(state), 32'd3);
        sens(12'd100, 12'd100, 12'd100);
        tick(48);
        sens(12'd100, 12'd3500, 12'd100);
        tick(1);
        chk("turn_min_edge", 32'(state), 32'd3);
        tick(1);
        chk("turn_reacq_state", 32'(state), 32'd1);
        chk("turn_reacq_idx", 32'(node_idx), 32'd2);
        probe_done = 1'b1;
        tick(1);
        chk("probe_ignored", 32'(probe_req), 32'd0);
        probe_done = 1'b0;

        // Node 2, sample.
        sens(12'd3500, 12'd3500, 12'd3500);
        tick(204);
        chk("sample_state", 32'(state), 32'd4);
        chk("sample_req", 32'(probe_req), 32'd1);
        chk("sample_m1", 32'(m1), 32'd0);
        chk("sample_m2", 32'(m2), 32'd0);
        sens(12'd100, 12'd100, 12'd100);
        tick(29);
        chk("sample_wait", 32'(state), 32'd4);
        probe_done = 1'b1;
        tick(1);
        probe_done = 1'b0;
        chk("probe_drop", 32'(probe_req), 32'd0);
        chk("sample_exit", 32'(state), 32'd1);
        chk("sample_idx", 32'(node_idx), 32'd3);
        tick(1);

        // Node 3, right turn; c already on line when the spin starts.
        sens(12'd3500, 12'd3500, 12'd3500);
        tick(204);
        chk("right_m1", 32'(m1), 32'd2);
        chk("right_m2", 32'(m2), 32'd1);
        sens(12'd100, 12'd3500, 12'd100);
        tick(100);
        chk("right_ignore", 32'(state), 32'd3);
        tick(1);
        chk("right_idx", 32'(node_idx), 32'd4);
        tick(1);

        // Node 4, straight and last.
        sens(12'd3500, 12'd3500, 12'd3500);
        tick(204);
        chk("done_state", 32'(state), 32'd5);
        chk("done_flag", 32'(done), 32'd1);
        chk("done_m1", 32'(m1), 32'd0);
        chk("done_idx", 32'(node_idx), 32'd4);
        tick(5);
        chk("done_hold", 32'(state), 32'd5);
        pulse_start();
        chk("restart_state", 32'(state), 32'd1);
        chk("restart_idx", 32'(node_idx), 32'd0);
        chk("restart_done", 32'(done), 32'd0);
        tick(10);
        chk("restart_unarmed", 32'(state), 32'd1);

        // Second pass: node 0 straight, node 1 spin without reacquire.
        sens(12'd100, 12'd100, 12'd100);
        tick(1);
        sens(12'd3500, 12'd3500, 12'd3500);
        tick(204);
        chk("pass2_idx", 32'(node_idx), 32'd1);
        sens(12'd100, 12'd100, 12'd100);
        tick(1);
        sens(12'd3500, 12'd3500, 12'd3500);
        tick(204);
        sens(12'd100, 12'd100, 12'd100);
        pulse_start();
        chk("turn_start_ign", 32'(state), 32'd3);
        tick(4998);
        chk("turn_pre_tmo", 32'(state), 32'd3);
        tick(1);
        chk("fault_state", 32'(state), 32'd6);
        chk("fault_flag", 32'(fault), 32'd1);
        chk("fault_m1", 32'(m1), 32'd0);
        chk("fault_m2", 32'(m2), 32'd0);
        pulse_start();
        chk("fault_sticky", 32'(state), 32'd6);
        rst_n = 1'b0;
        #1;
        chk("async_rst_state", 32'(state), 32'd0);
        chk("async_rst_fault", 32'(fault), 32'd0);
        chk("async_rst_idx", 32'(node_idx), 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(1);

`ifdef PROBE_TIMEOUT_EN
        pulse_start();
        sens(12'd3500, 12'd3500, 12'd3500);
        tick(204);
        sens(12'd100, 12'd100, 12'd100);
        tick(1);
        sens(12'd3500, 12'd3500, 12'd3500);
        tick(204);
        sens(12'd100, 12'd3500, 12'd100);
        tick(101);
        chk("ptmo_idx", 32'(node_idx), 32'd2);
        sens(12'd100, 12'd100, 12'd100);
        tick(1);
        sens(12'd3500, 12'd3500, 12'd3500);
        tick(204);
        chk("ptmo_sample", 32'(state), 32'd4);
        sens(12'd100, 12'd100, 12'd100);
        tick(19999);
        chk("ptmo_pre", 32'(state), 32'd4);
        tick(1);
        chk("ptmo_fault", 32'(state), 32'd6);
        chk("ptmo_req", 32'(probe_req), 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
